// File: rtl/mem16_access_ctrl.sv
// Two-requester arbiter and read/write sequencer in front of a 16-bit synchronous RAM.
// 32-bit byte-addressed reads become 2 (aligned) or 3 (unaligned) word reads.
module mem16_access_ctrl #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    output logic              req0_ready,
    output logic [31:0]       req0_rdata,
    output logic              req0_rvalid,
    input  logic              req1_valid,
    input  logic              req1_we,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [15:0]       req1_wdata,
    output logic              req1_ready,
    output logic [31:0]       req1_rdata,
    output logic              req1_rvalid,
    input  logic              big_endian,
    output logic [ADDR_W-2:0] ram_addr,
    output logic              ram_we,
    output logic [15:0]       ram_wdata,
    input  logic [15:0]       ram_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, RD, RLAST, WR} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              id_q, id_d;
    logic              we_q, we_d;
    logic              be_q, be_d;
    logic              prio_q, prio_d;
    logic [15:0]       wdata_q, wdata_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [23:0]       buf_q, buf_d;
    logic [31:0]       rdata0_q, rdata0_d, rdata1_q, rdata1_d;
    logic              rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;

    logic              grant1;
    logic [ADDR_W-2:0] word_q;
    logic [1:0]        last_k;
    logic [31:0]       be_word, result;

    assign word_q = addr_q[ADDR_W-1:1];
    assign last_k = addr_q[0] ? 2'd2 : 2'd1;
    assign grant1 = req1_valid && (!req0_valid || prio_q);

    // Final word arrives on ram_rdata during RLAST; earlier words sit in buf_q.
    assign be_word = addr_q[0] ? {buf_q, ram_rdata[15:8]} : {buf_q[15:0], ram_rdata};
    assign result  = be_q ? be_word : {be_word[7:0], be_word[15:8], be_word[23:16], be_word[31:24]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            id_q      <= 1'b0;
            we_q      <= 1'b0;
            be_q      <= 1'b0;
            prio_q    <= 1'b0;
            wdata_q   <= '0;
            cnt_q     <= '0;
            buf_q     <= '0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            id_q      <= id_d;
            we_q      <= we_d;
            be_q      <= be_d;
            prio_q    <= prio_d;
            wdata_q   <= wdata_d;
            cnt_q     <= cnt_d;
            buf_q     <= buf_d;
            rdata0_q  <= rdata0_d;
            rdata1_q  <= rdata1_d;
            rvalid0_q <= rvalid0_d;
            rvalid1_q <= rvalid1_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        id_d       = id_q;
        we_d       = we_q;
        be_d       = be_q;
        prio_d     = prio_q;
        wdata_d    = wdata_q;
        cnt_d      = cnt_q;
        buf_d      = buf_q;
        rdata0_d   = rdata0_q;
        rdata1_d   = rdata1_q;
        rvalid0_d  = 1'b0;
        rvalid1_d  = 1'b0;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        ram_addr   = '0;
        ram_we     = 1'b0;
        ram_wdata  = '0;

        case (state_q)
            IDLE: begin
                if (req0_valid || req1_valid) begin
                    req0_ready = !grant1;
                    req1_ready = grant1;
                    id_d       = grant1;
                    prio_d     = !grant1;
                    addr_d     = grant1 ? req1_addr : req0_addr;
                    we_d       = grant1 && req1_we;
                    wdata_d    = req1_wdata;
                    be_d       = big_endian;
                    cnt_d      = '0;
                    state_d    = (grant1 && req1_we) ? WR : RD;
                end
            end
            RD: begin
                ram_addr = word_q + (ADDR_W-1)'(cnt_q);
                if (cnt_q != 2'd0) begin
                    buf_d = {buf_q[7:0], ram_rdata};
                end
                if (cnt_q == last_k) begin
                    state_d = RLAST;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            RLAST: begin
                if (id_q) begin
                    rdata1_d  = result;
                    rvalid1_d = 1'b1;
                end else begin
                    rdata0_d  = result;
                    rvalid0_d = 1'b1;
                end
                state_d = IDLE;
            end
            WR: begin
                ram_addr  = word_q;
                ram_we    = 1'b1;
                ram_wdata = wdata_q;
                rvalid1_d = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign req0_rdata  = rdata0_q;
    assign req1_rdata  = rdata1_q;
    assign req0_rvalid = rvalid0_q;
    assign req1_rvalid = rvalid1_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_mem16_access_ctrl.sv
// Bench for mem16_access_ctrl: byte-array RAM environment plus a byte-level
// reference model; directed plan steps followed by randomized transactions.
module tb_mem16_access_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_ready, req0_rvalid;
    logic [7:0]  req0_addr;
    logic [31:0] req0_rdata;
    logic        req1_valid, req1_we, req1_ready, req1_rvalid;
    logic [7:0]  req1_addr;
    logic [15:0] req1_wdata;
    logic [31:0] req1_rdata;
    logic        big_endian;
    logic [6:0]  ram_addr;
    logic        ram_we;
    logic [15:0] ram_wdata;
    logic [15:0] ram_rdata;
    logic        busy;

    mem16_access_ctrl #(.ADDR_W(8)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_ready(req0_ready),
        .req0_rdata(req0_rdata), .req0_rvalid(req0_rvalid),
        .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr),
        .req1_wdata(req1_wdata), .req1_ready(req1_ready), .req1_rdata(req1_rdata),
        .req1_rvalid(req1_rvalid), .big_endian(big_endian),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    // RAM environment (byte view, 1-cycle read latency) and the model's own memory.
    logic [7:0] ram [256];
    logic [7:0] refm [256];
    logic       preload;

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 256; i++) ram[i] <= 8'(i);
        end else if (ram_we) begin
            ram[{ram_addr, 1'b0}] <= ram_wdata[15:8];
            ram[{ram_addr, 1'b1}] <= ram_wdata[7:0];
        end
        ram_rdata <= {ram[{ram_addr, 1'b0}], ram[{ram_addr, 1'b1}]};
    end

    int npass = 0;
    int ntotal = 0;
    logic [31:0] exp_last [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntotal++;
        assert (obs === exp) npass = npass + 1;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [31:0] exp_rd(input logic [7:0] a, input bit be);
        logic [7:0] b [4];
        for (int i = 0; i < 4; i++) b[i] = refm[8'(a + 8'(i))];
        return be ? {b[0], b[1], b[2], b[3]} : {b[3], b[2], b[1], b[0]};
    endfunction

    task automatic run(input int id, input bit we, input logic [7:0] a,
                       input logic [15:0] wd, input bit be);
        bit acc;
        int n;
        logic [31:0] exp;
        logic [6:0] w;
        @(negedge clk);
        if (id == 0) begin
            req0_valid = 1'b1; req0_addr = a;
        end else begin
            req1_valid = 1'b1; req1_we = we; req1_addr = a; req1_wdata = wd;
        end
        big_endian = be;
        acc = 1'b0;
        for (int c = 0; c < 20 && !acc; c++) begin
            #1;
            if ((id == 0) ? req0_ready : req1_ready) acc = 1'b1;
            else @(negedge clk);
        end
        if (!acc) begin
            chk("accept_timeout", 32'd0, 32'd1);
            req0_valid = 1'b0; req1_valid = 1'b0; req1_we = 1'b0;
            return;
        end
        chk("ready_other", {31'd0, (id == 0) ? req1_ready : req0_ready}, 32'd0);
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0; req1_we = 1'b0;
        w = a[7:1];
        if (we) begin
            chk("wr_we", {31'd0, ram_we}, 32'd1);
            chk("wr_addr", {25'd0, ram_addr}, {25'd0, w});
            chk("wr_data", {16'd0, ram_wdata}, {16'd0, wd});
            @(posedge clk); #1;
            chk("wr_rvalid", {30'd0, req0_rvalid, req1_rvalid}, 32'd1);
            chk("wr_we_off", {31'd0, ram_we}, 32'd0);
            chk("wr_rdata_hold", req1_rdata, exp_last[1]);
            chk("wr_idle", {31'd0, busy}, 32'd0);
            refm[{w, 1'b0}] = wd[15:8];
            refm[{w, 1'b1}] = wd[7:0];
        end else begin
            n = a[0] ? 3 : 2;
            exp = exp_rd(a, be);
            for (int k = 0; k < n; k++) begin
                chk("rd_addr", {25'd0, ram_addr}, {25'd0, 7'(w + 7'(k))});
                chk("rd_busy_we", {30'd0, busy, ram_we}, 32'd2);
                chk("rd_rvalid_early", {30'd0, req0_rvalid, req1_rvalid}, 32'd0);
                @(posedge clk); #1;
            end
            chk("rlast_addr", {25'd0, ram_addr}, 32'd0);
            chk("rlast_rvalid", {30'd0, req0_rvalid, req1_rvalid}, 32'd0);
            @(posedge clk); #1;
            chk("rd_rvalid", {30'd0, req0_rvalid, req1_rvalid}, (id == 0) ? 32'd2 : 32'd1);
            chk("rd_data", (id == 0) ? req0_rdata : req1_rdata, exp);
            chk("rd_other_hold", (id == 0) ? req1_rdata : req0_rdata, exp_last[1 - id]);
            chk("rd_idle", {31'd0, busy}, 32'd0);
            exp_last[id] = exp;
            @(posedge clk); #1;
            chk("rd_pulse_end", {30'd0, req0_rvalid, req1_rvalid}, 32'd0);
            chk("rd_data_hold", (id == 0) ? req0_rdata : req1_rdata, exp);
        end
    endtask

    initial begin
        int g [$];
        int gc0, gc1, rv0, rv1;
        logic r0, r1;
        int pulses;
        int id;
        bit we;

        rst = 1'b1; preload = 1'b1;
        req0_valid = 1'b0; req0_addr = '0;
        req1_valid = 1'b0; req1_we = 1'b0; req1_addr = '0; req1_wdata = '0;
        big_endian = 1'b0;
        for (int i = 0; i < 256; i++) refm[i] = 8'(i);
        exp_last[0] = '0; exp_last[1] = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_outs", {busy, ram_we, req0_ready, req1_ready, req0_rvalid, req1_rvalid, 25'd0, 1'b0},
            32'd0);
        chk("rst_ram_addr", {16'd0, ram_wdata ^ 16'd0} | {25'd0, ram_addr}, 32'd0);
        chk("rst_rdata", req0_rdata | req1_rdata, 32'd0);

        // Contention from reset: both requesters continuously reading.
        @(negedge clk);
        rst = 1'b0; preload = 1'b0;
        req0_valid = 1'b1; req0_addr = 8'h20;
        req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 8'h31;
        big_endian = 1'b1;
        gc0 = 0; gc1 = 0; rv0 = 0; rv1 = 0;
        for (int c = 0; c < 80 && !(gc0 == 2 && gc1 == 2 && rv0 == 2 && rv1 == 2); c++) begin
            #1;
            r0 = req0_ready; r1 = req1_ready;
            chk("no_double_grant", {31'd0, r0 & r1}, 32'd0);
            @(posedge clk); #1;
            if (r0) begin g.push_back(0); gc0++; if (gc0 == 2) req0_valid = 1'b0; end
            if (r1) begin g.push_back(1); gc1++; if (gc1 == 2) req1_valid = 1'b0; end
            if (req0_rvalid) begin rv0++; chk("cont_rd0", req0_rdata, exp_rd(8'h20, 1'b1)); end
            if (req1_rvalid) begin rv1++; chk("cont_rd1", req1_rdata, exp_rd(8'h31, 1'b1)); end
            @(negedge clk);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        chk("cont_grants", 32'(g.size()), 32'd4);
        for (int i = 0; i < g.size() && i < 4; i++) chk("cont_order", 32'(g[i]), 32'(i % 2));
        chk("cont_rvalid0", 32'(rv0), 32'd2);
        chk("cont_rvalid1", 32'(rv1), 32'd2);
        exp_last[0] = exp_rd(8'h20, 1'b1);
        exp_last[1] = exp_rd(8'h31, 1'b1);

        run(0, 1'b0, 8'h04, 16'h0, 1'b1);
        chk("plan_al_be", req0_rdata, 32'h04050607);
        run(0, 1'b0, 8'h04, 16'h0, 1'b0);
        chk("plan_al_le", req0_rdata, 32'h07060504);
        run(0, 1'b0, 8'h05, 16'h0, 1'b1);
        chk("plan_unal_be", req0_rdata, 32'h05060708);
        run(1, 1'b0, 8'hFF, 16'h0, 1'b1);
        chk("plan_wrap", req1_rdata, 32'hFF000102);
        run(1, 1'b1, 8'h10, 16'hBEEF, 1'b0);
        run(1, 1'b0, 8'h10, 16'h0, 1'b1);
        chk("plan_wr_rd", req1_rdata, 32'hBEEF1213);

        // Reset between E1 and E2 of an unaligned read.
        @(negedge clk);
        req0_valid = 1'b1; req0_addr = 8'h05; big_endian = 1'b1;
        #1;
        chk("abort_ready", {31'd0, req0_ready}, 32'd1);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        @(posedge clk); #2;
        chk("abort_busy_pre", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        #1;
        chk("abort_outs", {29'd0, busy, ram_we, req0_rvalid}, 32'd0);
        chk("abort_addr", {25'd0, ram_addr}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        exp_last[0] = '0; exp_last[1] = '0;
        pulses = 0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            if (req0_rvalid || req1_rvalid || busy) pulses++;
        end
        chk("abort_quiet", 32'(pulses), 32'd0);
        run(0, 1'b0, 8'h00, 16'h0, 1'b1);
        chk("plan_after_rst", req0_rdata, 32'h00010203);

        for (int t = 0; t < 40; t++) begin
            id = int'($urandom_range(0, 1));
            we = (id == 1) && ($urandom_range(0, 2) == 0);
            run(id, we, 8'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
